// File: rtl/cbu_issue_pkg.sv
// Shared types and constants for the CBU issue queue and sequencer.
package cbu_issue_pkg;

    localparam int INSTR_W = 9;
    localparam int OPND_W  = 4;
    localparam int OP_W    = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OP_W-1:0] OP_INC   = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC   = 3'b011;
    localparam logic [OP_W-1:0] OP_CMP   = 3'b100;
    localparam logic [OP_W-1:0] OP_CNTUP = 3'b101;
    localparam logic [OP_W-1:0] OP_CNTDN = 3'b110;
    localparam logic [OP_W-1:0] OP_MUL2  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [OPND_W-1:0]  a;
        logic [OPND_W-1:0]  b;
    } entry_t;

    // Counter opcodes must stay parked at the CBU for the dwell period.
    function automatic logic is_dwell_op(input logic [INSTR_W-1:0] instr);
        return (instr[INSTR_W-1 -: OP_W] == OP_CNTUP) ||
               (instr[INSTR_W-1 -: OP_W] == OP_CNTDN);
    endfunction

endpackage

// File: rtl/cbu_issue_fifo.sv
// Circular instruction queue of DEPTH {instr, a, b} entries; head visible combinationally.
// Push and pop take effect on the clock edge; a push into a full queue is ignored, flush wins over push.
module cbu_issue_fifo
    import cbu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 push_dat,
    output entry_t                 head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        push_ok  = push && (count_q < CW'(DEPTH)) && !flush;
        pop_ok   = pop && (count_q != '0) && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is qualified by pointers and count, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/cbu_issue.sv
// Queues instructions and issues them to the CBU one per cycle, parking counter ops for CNT_DWELL cycles.
// Issue is registered (>=2 cycles from push); res_valid trails issue_valid by CBU_LAT; wr_ready drops when the queue is full.
module cbu_issue
    import cbu_issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_DWELL = 16,
    parameter int CBU_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [INSTR_W-1:0]     wr_instr,
    input  logic [OPND_W-1:0]      wr_a,
    input  logic [OPND_W-1:0]      wr_b,
    output logic [INSTR_W-1:0]     cbu_in,
    output logic [OPND_W-1:0]      cbu_a,
    output logic [OPND_W-1:0]      cbu_b,
    output logic                   issue_valid,
    output logic                   res_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(CNT_DWELL + 1);

    state_t             state_q, state_d;
    entry_t             out_q, out_d;
    logic               issue_valid_q, issue_valid_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [CBU_LAT-1:0] res_pipe_q, res_pipe_d;
    logic               push;
    logic               pop;
    logic               do_issue;
    entry_t             head;
    entry_t             push_dat;

    assign wr_ready = (fifo_count < CW'(DEPTH));
    assign push     = wr_valid && wr_ready;
    assign push_dat = '{instr: wr_instr, a: wr_a, b: wr_b};

    cbu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .pop      (pop),
        .push_dat (push_dat),
        .head_dat (head),
        .count    (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        issue_valid_d = issue_valid_q;
        dwell_d       = dwell_q;
        res_pipe_d    = res_pipe_q;
        pop           = 1'b0;
        do_issue      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d         = '0;
                issue_valid_d = 1'b0;
                dwell_d       = '0;
                if (fifo_count != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fifo_count != '0) begin
                    do_issue = 1'b1;
                end else begin
                    state_d       = ST_IDLE;
                    out_d         = '0;
                    issue_valid_d = 1'b0;
                end
            end
            ST_DWELL: begin
                // The last held cycle issues the next entry directly so issue_valid never gaps.
                if (dwell_q >= DW'(CNT_DWELL)) begin
                    if (fifo_count != '0) begin
                        do_issue = 1'b1;
                    end else begin
                        state_d       = ST_IDLE;
                        out_d         = '0;
                        issue_valid_d = 1'b0;
                        dwell_d       = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_issue) begin
            pop           = 1'b1;
            out_d         = head;
            issue_valid_d = 1'b1;
            if (is_dwell_op(head.instr)) begin
                state_d = ST_DWELL;
                dwell_d = DW'(1);
            end else begin
                dwell_d = '0;
                state_d = ((fifo_count == CW'(1)) && !push) ? ST_IDLE : ST_ISSUE;
            end
        end

        res_pipe_d[0] = issue_valid_q;
        for (int i = 1; i < CBU_LAT; i++) begin
            res_pipe_d[i] = res_pipe_q[i-1];
        end

        if (flush) begin
            state_d       = ST_IDLE;
            out_d         = '0;
            issue_valid_d = 1'b0;
            dwell_d       = '0;
            res_pipe_d    = '0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            out_q         <= '0;
            issue_valid_q <= 1'b0;
            dwell_q       <= '0;
            res_pipe_q    <= '0;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            issue_valid_q <= issue_valid_d;
            dwell_q       <= dwell_d;
            res_pipe_q    <= res_pipe_d;
        end
    end

    assign cbu_in      = out_q.instr;
    assign cbu_a       = out_q.a;
    assign cbu_b       = out_q.b;
    assign issue_valid = issue_valid_q;
    assign res_valid   = res_pipe_q[CBU_LAT-1];
    assign busy        = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cbu_issue.sv
// Directed bench for cbu_issue: reset, back-to-back issue, dwell, full queue, pointer wrap, flush and async reset.
module tb_cbu_issue;

    localparam logic [8:0] I_ADD   = 9'b000_000000;
    localparam logic [8:0] I_SUB   = 9'b001_000000;
    localparam logic [8:0] I_INC   = 9'b010_000000;
    localparam logic [8:0] I_CNTUP = 9'b101_000011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_valid = 1'b0;
    logic [8:0] wr_instr = '0;
    logic [3:0] wr_a = '0;
    logic [3:0] wr_b = '0;
    logic       wr_ready;
    logic [8:0] cbu_in;
    logic [3:0] cbu_a;
    logic [3:0] cbu_b;
    logic       issue_valid;
    logic       res_valid;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic bb_iv  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   bb_a   [8] = '{0, 0, 6, 10, 7, 0, 0, 0};
    logic bb_res [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    cbu_issue #(
        .DEPTH     (4),
        .CNT_DWELL (16),
        .CBU_LAT   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_instr    (wr_instr),
        .wr_a        (wr_a),
        .wr_b        (wr_b),
        .cbu_in      (cbu_in),
        .cbu_a       (cbu_a),
        .cbu_b       (cbu_b),
        .issue_valid (issue_valid),
        .res_valid   (res_valid),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] ins, input logic [3:0] a, input logic [3:0] b);
        wr_valid = v;
        wr_instr = ins;
        wr_a     = a;
        wr_b     = b;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (2) step();
        checks++;
        if ({cbu_in, cbu_a, cbu_b} !== 17'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {cbu_in, cbu_a, cbu_b});
        end
        checks++;
        if (issue_valid !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids got iv=%b res=%b want 0 0", issue_valid, res_valid);
        end
        checks++;
        if (fifo_count !== 3'd0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_queue got cnt=%0d rdy=%b busy=%b want 0 1 0", fifo_count, wr_ready, busy);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            case (k)
                0:       drive(1'b1, I_ADD, 4'd6, 4'd3);
                1:       drive(1'b1, I_ADD, 4'd10, 4'd7);
                2:       drive(1'b1, I_SUB, 4'd7, 4'd2);
                default: drive(1'b0, '0, '0, '0);
            endcase
            step();
            checks++;
            if (issue_valid !== bb_iv[k] || int'(cbu_a) != bb_a[k]) begin
                errors++; $display("FAIL b2b_issue cyc%0d got iv=%b a=%0d want iv=%b a=%0d", k, issue_valid, cbu_a, bb_iv[k], bb_a[k]);
            end
            checks++;
            if (res_valid !== bb_res[k]) begin
                errors++; $display("FAIL b2b_res cyc%0d got %b want %b", k, res_valid, bb_res[k]);
            end
            if (k == 4) begin
                checks++;
                if (cbu_in !== I_SUB || cbu_b !== 4'd2) begin
                    errors++; $display("FAIL b2b_third got in=%b b=%0d want in=%b b=2", cbu_in, cbu_b, I_SUB);
                end
            end
            if (k == 5) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL b2b_busy got %b want 0", busy);
                end
            end
        end
    endtask

    task automatic test_dwell();
        int held = 0;
        drive(1'b1, I_CNTUP, 4'd1, 4'd2);
        step();
        drive(1'b1, I_INC, 4'd3, 4'd0);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        for (int i = 0; i < 16; i++) begin
            if (issue_valid === 1'b1 && cbu_in === I_CNTUP) held++;
            step();
        end
        checks++;
        if (held != 16) begin
            errors++; $display("FAIL dwell_hold got %0d cycles want 16", held);
        end
        checks++;
        if (issue_valid !== 1'b1 || cbu_in !== I_INC || cbu_a !== 4'd3) begin
            errors++; $display("FAIL dwell_next got iv=%b in=%b a=%0d want iv=1 in=%b a=3", issue_valid, cbu_in, cbu_a, I_INC);
        end
        step();
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++; $display("FAIL dwell_idle got iv=%b want 0", issue_valid);
        end
    endtask

    task automatic test_full_queue();
        int   seen[$];
        int   wait_n = 0;
        logic rdy;
        logic accepted = 1'b0;
        logic over = 1'b0;
        drive(1'b1, I_CNTUP, 4'd0, 4'd0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, I_ADD, 4'(i), 4'd0);
            step();
        end
        checks++;
        if (fifo_count !== 3'd4 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL full_level got cnt=%0d rdy=%b want 4 0", fifo_count, wr_ready);
        end
        drive(1'b1, I_ADD, 4'd5, 4'd0);
        for (int i = 0; i < 40 && !accepted; i++) begin
            rdy = wr_ready;
            step();
            wait_n++;
            if (issue_valid === 1'b1 && cbu_in[8:6] === 3'b000) seen.push_back(int'(cbu_a));
            if (fifo_count > 3'd4) over = 1'b1;
            if (rdy === 1'b1) accepted = 1'b1;
        end
        checks++;
        if (!accepted || wait_n != 15) begin
            errors++; $display("FIFTH accepted=%b", accepted);
            $display("FAIL full_fifth_wait got %0d cycles want 15", wait_n);
        end
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++; $display("FAIL full_after_accept got cnt=%0d want 3", fifo_count);
        end
        drive(1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (issue_valid === 1'b1 && cbu_in[8:6] === 3'b000) seen.push_back(int'(cbu_a));
            if (fifo_count > 3'd4) over = 1'b1;
        end
        checks++;
        if (seen.size() != 5 || over) begin
            errors++; $display("FAIL full_count got %0d issued over=%b want 5 0", seen.size(), over);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] != i + 1) begin
                    errors++; $display("FAIL full_order idx%0d got %0d want %0d", i, seen[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int   seen[$];
        int   idx = 0;
        int   max_cnt = 0;
        logic rdy;
        for (int c = 0; c < 40; c++) begin
            if (idx < 10) drive(1'b1, I_ADD, 4'(idx), 4'(9 - idx));
            else          drive(1'b0, '0, '0, '0);
            rdy = wr_ready;
            step();
            if (idx < 10 && rdy === 1'b1) idx++;
            if (issue_valid === 1'b1) seen.push_back(int'(cbu_a));
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        checks++;
        if (seen.size() != 10 || max_cnt > 4) begin
            errors++; $display("FAIL wrap_count got %0d issued max_cnt=%0d want 10 <=4", seen.size(), max_cnt);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (seen[i] != i) begin
                    errors++; $display("FAIL wrap_order idx%0d got %0d want %0d", i, seen[i], i);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        logic stray = 1'b0;
        drive(1'b1, I_CNTUP, 4'd0, 4'd0);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, I_ADD, 4'(i), 4'd0);
            step();
        end
        checks++;
        if (fifo_count !== 3'd3 || issue_valid !== 1'b1) begin
            errors++; $display("FAIL flush_setup got cnt=%0d iv=%b want 3 1", fifo_count, issue_valid);
        end
        flush = 1'b1;
        drive(1'b1, I_ADD, 4'd4, 4'd0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        checks++;
        if (fifo_count !== 3'd0 || issue_valid !== 1'b0 || {cbu_in, cbu_a, cbu_b} !== 17'd0) begin
            errors++; $display("FAIL flush_clear got cnt=%0d iv=%b out=%h want 0 0 0", fifo_count, issue_valid, {cbu_in, cbu_a, cbu_b});
        end
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL flush_flags got res=%b busy=%b rdy=%b want 0 0 1", res_valid, busy, wr_ready);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (issue_valid !== 1'b0 || res_valid !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL flush_stray got activity=1 want 0");
        end

        drive(1'b1, I_CNTUP, 4'd5, 4'd6);
        step();
        drive(1'b1, I_ADD, 4'd7, 4'd0);
        step();
        drive(1'b1, I_ADD, 4'd8, 4'd0);
        step();
        drive(1'b0, '0, '0, '0);
        repeat (3) step();
        checks++;
        if (issue_valid !== 1'b1 || res_valid !== 1'b1 || fifo_count !== 3'd2 || cbu_a !== 4'd5) begin
            errors++; $display("FAIL rst_setup got iv=%b res=%b cnt=%0d a=%0d want 1 1 2 5", issue_valid, res_valid, fifo_count, cbu_a);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cbu_in, cbu_a, cbu_b} !== 17'd0 || issue_valid !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async_out got out=%h iv=%b res=%b want 0 0 0", {cbu_in, cbu_a, cbu_b}, issue_valid, res_valid);
        end
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL rst_async_queue got cnt=%0d busy=%b rdy=%b want 0 0 1", fifo_count, busy, wr_ready);
        end
        repeat (2) step();
        rst = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (issue_valid !== 1'b0 || fifo_count !== 3'd0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL rst_replay got activity=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_dwell();
        test_full_queue();
        test_wrap();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached want finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
